// File: rtl/conv_pe_if.sv
// Window/ROM/output bundle between the line buffer, weight+bias ROMs, the PE and the output FIFO.
// The PE takes the slave view; the surrounding datapath takes the master view.
interface conv_pe_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int IN_CHANNEL  = 16,
  parameter int OUT_CHANNEL = 8,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3
);
  localparam int KERNEL_PTS = KERNEL_0 * KERNEL_1;
  localparam int WA_W = ($clog2(OUT_CHANNEL * KERNEL_PTS) > 0) ? $clog2(OUT_CHANNEL * KERNEL_PTS) : 1;
  localparam int BA_W = ($clog2(OUT_CHANNEL) > 0) ? $clog2(OUT_CHANNEL) : 1;

  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] i_data;
  logic                                        i_valid;
  logic                                        pe_ready;
  logic                                        pe_ack;
  logic [WA_W-1:0]                             weight_addr;
  logic [DATA_WIDTH*IN_CHANNEL-1:0]            weight_data;
  logic [BA_W-1:0]                             bias_addr;
  logic [DATA_WIDTH-1:0]                       bias_data;
  logic [DATA_WIDTH*OUT_CHANNEL-1:0]           o_data;
  logic                                        o_valid;

  modport slave (
    input  i_data, i_valid, weight_data, bias_data,
    output pe_ready, pe_ack, weight_addr, bias_addr, o_data, o_valid
  );

  modport master (
    output i_data, i_valid, weight_data, bias_data,
    input  pe_ready, pe_ack, weight_addr, bias_addr, o_data, o_valid
  );
endinterface

// File: rtl/conv_pe.sv
// Convolution PE: latches one window, walks the weight ROM one (oc,k) per cycle,
// accumulates bias + dot products, then requantizes (floor, saturate, optional ReLU).
module conv_pe #(
  parameter int DATA_WIDTH  = 16,
  parameter int IN_CHANNEL  = 16,
  parameter int OUT_CHANNEL = 8,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3,
  parameter int FRAC_BITS   = 8,
  parameter int RELU        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  conv_pe_if.slave   bus
);
  localparam int KERNEL_PTS = KERNEL_0 * KERNEL_1;
  localparam int N          = OUT_CHANNEL * KERNEL_PTS;
  localparam int WA_W  = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int BA_W  = ($clog2(OUT_CHANNEL) > 0) ? $clog2(OUT_CHANNEL) : 1;
  localparam int KW    = ($clog2(KERNEL_PTS) > 0) ? $clog2(KERNEL_PTS) : 1;
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(IN_CHANNEL * KERNEL_PTS) + 2;
  localparam int WIN_W = DATA_WIDTH * IN_CHANNEL * KERNEL_PTS;
  localparam int OUT_W = DATA_WIDTH * OUT_CHANNEL;

  localparam logic [WA_W-1:0] ADDR_LAST = WA_W'(N - 1);
  localparam logic [KW-1:0]   K_LAST    = KW'(KERNEL_PTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic [WA_W-1:0]           addr_q, addr_d;
  logic [KW-1:0]             k_q, k_d;
  logic [BA_W-1:0]           oc_q, oc_d;
  logic                      mac_en_q, mac_en_d;
  logic [KW-1:0]             mac_k_q, mac_k_d;
  logic [BA_W-1:0]           mac_oc_q, mac_oc_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          o_data_q, o_data_d;
  logic                      pe_ack_q, pe_ack_d;

  logic                      pe_ready;
  logic                      accept;
  logic signed [ACC_W-1:0]   prod_ext [IN_CHANNEL];
  logic signed [ACC_W-1:0]   dot;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_WIDTH-1:0] q;

  assign pe_ready = (state_q == IDLE) || (state_q == DONE);
  assign accept   = bus.i_valid && pe_ready;

  // MAC stage consumes the ROM word addressed in the previous cycle.
  genvar gi;
  generate
    for (gi = 0; gi < IN_CHANNEL; gi++) begin : g_mul
      logic signed [DATA_WIDTH-1:0]   act;
      logic signed [DATA_WIDTH-1:0]   wgt;
      logic signed [2*DATA_WIDTH-1:0] prod;
      assign act  = win_q[(int'(mac_k_q) * IN_CHANNEL + gi) * DATA_WIDTH +: DATA_WIDTH];
      assign wgt  = bus.weight_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign prod = act * wgt;
      assign prod_ext[gi] = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  endgenerate

  always_comb begin
    dot = '0;
    for (int c = 0; c < IN_CHANNEL; c++) begin
      dot = dot + prod_ext[c];
    end
    bias_ext = {{(ACC_W-DATA_WIDTH){bus.bias_data[DATA_WIDTH-1]}}, bus.bias_data};
    // First kernel point restarts the sum from the bias instead of the previous channel.
    acc_sum  = ((mac_k_q == '0) ? (bias_ext <<< FRAC_BITS) : acc_q) + dot;
    shifted  = acc_sum >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      q = shifted[DATA_WIDTH-1:0];
    end
    if ((RELU != 0) && q[DATA_WIDTH-1]) begin
      q = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    addr_d   = addr_q;
    k_d      = k_q;
    oc_d     = oc_q;
    mac_en_d = 1'b0;
    mac_k_d  = mac_k_q;
    mac_oc_d = mac_oc_q;
    acc_d    = acc_q;
    o_data_d = o_data_q;
    pe_ack_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = FETCH;
          win_d    = bus.i_data;
          addr_d   = '0;
          k_d      = '0;
          oc_d     = '0;
          pe_ack_d = 1'b1;
        end
      end
      FETCH: begin
        mac_en_d = 1'b1;
        mac_k_d  = k_q;
        mac_oc_d = oc_q;
        if (addr_q == ADDR_LAST) begin
          state_d = LAST;
        end else begin
          addr_d = addr_q + WA_W'(1);
          if (k_q == K_LAST) begin
            k_d  = '0;
            oc_d = oc_q + BA_W'(1);
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      LAST: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mac_en_q) begin
      acc_d = acc_sum;
      if (mac_k_q == K_LAST) begin
        o_data_d[int'(mac_oc_q)*DATA_WIDTH +: DATA_WIDTH] = q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      oc_q     <= '0;
      mac_en_q <= 1'b0;
      mac_k_q  <= '0;
      mac_oc_q <= '0;
      acc_q    <= '0;
      o_data_q <= '0;
      pe_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      oc_q     <= oc_d;
      mac_en_q <= mac_en_d;
      mac_k_q  <= mac_k_d;
      mac_oc_q <= mac_oc_d;
      acc_q    <= acc_d;
      o_data_q <= o_data_d;
      pe_ack_q <= pe_ack_d;
    end
  end

  assign bus.pe_ready    = pe_ready;
  assign bus.pe_ack      = pe_ack_q;
  assign bus.weight_addr = addr_q;
  assign bus.bias_addr   = oc_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_valid     = (state_q == DONE);

endmodule
